// File: rtl/kim_mips_pkg.sv
// kim_mips_pkg
// Widths and constants for the MIPS register file. The pipeline registers
// and the forwarding unit use the same package.
package kim_mips_pkg;

    localparam int MIPS_REGISTER_DATA_WIDTH = 32;
    localparam int MIPS_REGISTER_ADDR_WIDTH = 5;
    localparam int NUM_REGS                 = 32;
    localparam logic [MIPS_REGISTER_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
    localparam int RETIRE_CNT_WIDTH         = 32;

endpackage

// File: rtl/kim_wb_regfile_if.sv
// kim_wb_regfile_if
// Signals between the MEM/WB register, the ID stage, the forwarding unit
// and the write-back / register-file block.
//   master : drives MEM/WB fields and the ID read addresses; samples the
//            read data, the write-back export and retire_cnt
//   slave  : the write-back / register-file block
interface kim_wb_regfile_if
    import kim_mips_pkg::*;
#(
    parameter int DATA_WIDTH = MIPS_REGISTER_DATA_WIDTH,
    parameter int ADDR_WIDTH = MIPS_REGISTER_ADDR_WIDTH
) ();
    logic                        MemtoReg;
    logic                        RegWrite;
    logic [DATA_WIDTH-1:0]       r_data;
    logic [DATA_WIDTH-1:0]       alu_result;
    logic [ADDR_WIDTH-1:0]       MEM_WB_Rt_or_Rd;
    logic [ADDR_WIDTH-1:0]       rs_addr;
    logic [ADDR_WIDTH-1:0]       rt_addr;
    logic [DATA_WIDTH-1:0]       rs_data;
    logic [DATA_WIDTH-1:0]       rt_data;
    logic [DATA_WIDTH-1:0]       wb_data;
    logic                        wb_we;
    logic [ADDR_WIDTH-1:0]       wb_addr;
    logic [RETIRE_CNT_WIDTH-1:0] retire_cnt;

    modport master (
        output MemtoReg, RegWrite, r_data, alu_result, MEM_WB_Rt_or_Rd,
               rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, wb_we, wb_addr, retire_cnt
    );

    modport slave (
        input  MemtoReg, RegWrite, r_data, alu_result, MEM_WB_Rt_or_Rd,
               rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, wb_we, wb_addr, retire_cnt
    );
endinterface

// File: rtl/kim_regfile_2r1w.sv
// kim_regfile_2r1w
// Storage array: one synchronous write port, two raw asynchronous read
// ports. Asynchronous reset clears every entry. No zero-register masking
// and no bypass here; the parent handles both.
//   clk, rstn        : clock, async active-low reset
//   we, waddr, wdata : write port
//   raddr_a/rdata_a  : read port A
//   raddr_b/rdata_b  : read port B
module kim_regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/kim_wb_regfile.sv
// kim_wb_regfile
// MIPS write-back stage plus architectural register file. Selects load data
// or ALU result, commits it to the 32x32 array, and serves two ID-stage read
// ports. The read ports bypass the in-flight write, so a WB->ID dependency
// in the same cycle needs no stall. Also counts cycles with RegWrite set.
//   clk, rstn : clock, async active-low reset
//   bus       : kim_wb_regfile_if.slave (MEM/WB inputs, read ports,
//               write-back export, retire_cnt)
module kim_wb_regfile
    import kim_mips_pkg::*;
#(
    parameter int DATA_WIDTH = MIPS_REGISTER_DATA_WIDTH,
    parameter int ADDR_WIDTH = MIPS_REGISTER_ADDR_WIDTH,
    parameter int NUM_REGS   = kim_mips_pkg::NUM_REGS
) (
    input  logic             clk,
    input  logic             rstn,
    kim_wb_regfile_if.slave  bus
);
    logic [DATA_WIDTH-1:0]       wb_data;
    logic                        wb_we;
    logic [DATA_WIDTH-1:0]       raw_a;
    logic [DATA_WIDTH-1:0]       raw_b;
    logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_q;

    assign wb_data = bus.MemtoReg ? bus.r_data : bus.alu_result;
    // rstn gates the enable so that, while reset is held, the bypass cannot
    // leak a value past the cleared array.
    assign wb_we   = rstn & bus.RegWrite & (bus.MEM_WB_Rt_or_Rd != REG_ZERO);

    kim_regfile_2r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_rf (
        .clk     (clk),
        .rstn    (rstn),
        .we      (wb_we),
        .waddr   (bus.MEM_WB_Rt_or_Rd),
        .wdata   (wb_data),
        .raddr_a (bus.rs_addr),
        .rdata_a (raw_a),
        .raddr_b (bus.rt_addr),
        .rdata_b (raw_b)
    );

    always_comb begin
        bus.rs_data = raw_a;
        if (bus.rs_addr == REG_ZERO) begin
            bus.rs_data = '0;
        end else if (wb_we && (bus.MEM_WB_Rt_or_Rd == bus.rs_addr)) begin
            bus.rs_data = wb_data;
        end
    end

    always_comb begin
        bus.rt_data = raw_b;
        if (bus.rt_addr == REG_ZERO) begin
            bus.rt_data = '0;
        end else if (wb_we && (bus.MEM_WB_Rt_or_Rd == bus.rt_addr)) begin
            bus.rt_data = wb_data;
        end
    end

    // Writes to $zero still count as retired; they are only discarded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retire_cnt_q <= '0;
        end else if (bus.RegWrite) begin
            retire_cnt_q <= retire_cnt_q + 1'b1;
        end
    end

    assign bus.wb_data    = wb_data;
    assign bus.wb_we      = wb_we;
    assign bus.wb_addr    = bus.MEM_WB_Rt_or_Rd;
    assign bus.retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_kim_wb_regfile.sv
module tb_kim_wb_regfile;
    import kim_mips_pkg::*;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fails;

    kim_wb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    kim_wb_regfile #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .NUM_REGS   (32)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] dest);
        bus.RegWrite        = we;
        bus.MemtoReg        = m2r;
        bus.r_data          = rd;
        bus.alu_result      = alu;
        bus.MEM_WB_Rt_or_Rd = dest;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.rs_addr = a;
        bus.rt_addr = a;
        #1;
        chk({tag, "_rs"}, bus.rs_data, exp);
        chk({tag, "_rt"}, bus.rt_data, exp);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rstn     = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd0;

        // Reset: all reads zero, counter zero.
        #3;
        for (int i = 0; i < 32; i++) begin
            rd_chk("rst_read", 5'(i), 32'h0);
        end
        chk("rst_retire", bus.retire_cnt, 32'h0);

        @(negedge clk);
        rstn = 1'b1;

        // ALU write to r5 with same-cycle bypass.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h1234_5678, 5'd5);
        bus.rs_addr = 5'd5;
        bus.rt_addr = 5'd0;
        #1;
        chk("byp5_rs", bus.rs_data, 32'h1234_5678);
        chk("byp5_rt0", bus.rt_data, 32'h0);
        chk("byp5_we", {31'b0, bus.wb_we}, 32'h1);
        chk("byp5_addr", {27'b0, bus.wb_addr}, 32'd5);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd5);
        #1;
        chk("st5_rs", bus.rs_data, 32'h1234_5678);
        chk("st5_we", {31'b0, bus.wb_we}, 32'h0);
        chk("retire_1", bus.retire_cnt, 32'd1);

        // Load-data path to r31.
        @(negedge clk);
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd31);
        #1;
        chk("ld31_wbdata", bus.wb_data, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rd_chk("st31", 5'd31, 32'hDEAD_BEEF);
        chk("retire_2", bus.retire_cnt, 32'd2);

        // Write to $zero: discarded but retired.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd0;
        #1;
        chk("z_we", {31'b0, bus.wb_we}, 32'h0);
        chk("z_rs", bus.rs_data, 32'h0);
        chk("z_rt", bus.rt_data, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        chk("z_retire", bus.retire_cnt, 32'd3);
        rd_chk("z_after", 5'd0, 32'h0);

        // r7 = 0x11, then both ports see the in-flight 0xA5A5A5A5.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h11, 5'd7);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'hA5A5_A5A5, 5'd7);
        rd_chk("dual_byp7", 5'd7, 32'hA5A5_A5A5);
        drive(1'b0, 1'b0, 32'h0, 32'hA5A5_A5A5, 5'd7);
        rd_chk("dual_old7", 5'd7, 32'h11);
        rd_chk("keep5", 5'd5, 32'h1234_5678);
        chk("retire_4", bus.retire_cnt, 32'd4);

        // Counter wrap.
        @(negedge clk);
        dut.retire_cnt_q = 32'hFFFF_FFFE;
        #1;
        chk("wrap_pre", bus.retire_cnt, 32'hFFFF_FFFE);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        chk("wrap_ffff", bus.retire_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        chk("wrap_zero", bus.retire_cnt, 32'h0);

        // Mid-run reset: everything reads zero at once, bypass disabled.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h7777_7777, 5'd5);
        rstn = 1'b0;
        #1;
        chk("mrst_we", {31'b0, bus.wb_we}, 32'h0);
        rd_chk("mrst_r5", 5'd5, 32'h0);
        rd_chk("mrst_r7", 5'd7, 32'h0);
        rd_chk("mrst_r31", 5'd31, 32'h0);
        chk("mrst_retire", bus.retire_cnt, 32'h0);

        // First write after release lands on the first edge with rstn high.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h33, 5'd3);
        rstn = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rd_chk("post_r3", 5'd3, 32'h33);
        rd_chk("post_r5", 5'd5, 32'h0);
        chk("post_retire", bus.retire_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
